// File: rtl/if_stage_pkg.sv
// if_stage_pkg: bus widths, next-PC select encodings and fetch FSM states.
package if_stage_pkg;
  localparam int IF_TO_ID_BUS_WD = 64;
  localparam int ID_TO_PC_BUS_WD = 98;
  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JAL = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} if_state_t;
endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request, valid/allow-in handoff
// to decode, and a latched delay-slot redirect from decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       inst_req,
  output logic [31:0]                inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata,
  output logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_bus,
  output logic                       IF_to_ID_valid,
  input  logic                       ID_allow_in,
  input  logic [ID_TO_PC_BUS_WD-1:0] ID_to_PC_bus
);
  if_state_t   r_state, w_next_state;
  logic [31:0] r_fetch_pc, r_out_inst, r_out_pc4, r_pend_pc;
  logic        r_valid, r_pend_vld;
  logic        w_handoff;
  logic [1:0]  w_sel;
  logic [31:0] w_target, w_next_pc, w_pc4;

  assign w_sel     = ID_to_PC_bus[1:0];
  assign w_handoff = (r_state == S_HOLD) && ID_allow_in;
  assign w_pc4     = r_fetch_pc + 32'd4;
  assign w_target  = (w_sel == SEL_BR)  ? ID_to_PC_bus[97:66] :
                     (w_sel == SEL_JAL) ? ID_to_PC_bus[65:34] : ID_to_PC_bus[33:2];
  // A live redirect outranks the latched one so a same-cycle handoff never loses it.
  assign w_next_pc = (w_sel != SEL_SEQ) ? w_target : r_pend_vld ? r_pend_pc : w_pc4;

  assign inst_req       = (r_state == S_REQ);
  assign inst_addr      = r_fetch_pc;
  assign IF_to_ID_bus   = {r_out_pc4, r_out_inst};
  assign IF_to_ID_valid = r_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ:   w_next_state = inst_addr_ok ? S_WAIT : S_REQ;
      S_WAIT:  w_next_state = inst_data_ok ? S_HOLD : S_WAIT;
      default: w_next_state = ID_allow_in ? S_REQ : S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_out_inst <= '0;
      r_out_pc4  <= '0;
      r_valid    <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_WAIT && inst_data_ok) begin
        r_out_inst <= inst_rdata;
        r_out_pc4  <= w_pc4;
        r_valid    <= 1'b1;
      end
      if (w_handoff) begin
        r_fetch_pc <= {w_next_pc[31:2], 2'b00};
        r_valid    <= 1'b0;
        r_pend_vld <= 1'b0;
      end else if (w_sel != SEL_SEQ) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= w_target;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed fetch sequence with a scoreboard of expected decode-bus words.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0, ID_allow_in = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [97:0] ID_to_PC_bus = '0;
  logic        req0, req1, vld0, vld1;
  logic [31:0] addr0, addr1;
  logic [63:0] bus0, bus1;
  logic [63:0] sb[$];
  int          n_cmp = 0, n_fail = 0;

  if_stage u0 (
    .clk(clk), .reset(reset), .inst_req(req0), .inst_addr(addr0),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .IF_to_ID_bus(bus0), .IF_to_ID_valid(vld0), .ID_allow_in(ID_allow_in),
    .ID_to_PC_bus(ID_to_PC_bus)
  );

  if_stage #(.RESET_PC(32'hFFFFFFFC)) u1 (
    .clk(clk), .reset(reset), .inst_req(req1), .inst_addr(addr1),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .IF_to_ID_bus(bus1), .IF_to_ID_valid(vld1), .ID_allow_in(ID_allow_in),
    .ID_to_PC_bus(ID_to_PC_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                       input logic [97:0] redir, input int dly);
    int n;
    n = 0;
    while (!req0 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {63'b0, req0}, 64'd1);
    chk("req_addr", {32'b0, addr0}, {32'b0, exp_addr});
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("wait_req_low", {63'b0, req0}, 64'd0);
    for (int i = 0; i < dly; i++) begin
      ID_to_PC_bus = redir;
      tick();
    end
    ID_to_PC_bus = '0;
    inst_data_ok = 1'b1;
    inst_rdata   = word;
    sb.push_back({exp_addr + 32'd4, word});
    tick();
    inst_data_ok = 1'b0;
    chk("valid_set", {63'b0, vld0}, 64'd1);
    if (sb.size() > 0) chk("bus", bus0, sb.pop_front());
    else chk("sb_empty", 64'd1, 64'd0);
  endtask

  task automatic handoff(input logic [97:0] redir);
    ID_allow_in  = 1'b1;
    ID_to_PC_bus = redir;
    tick();
    ID_allow_in  = 1'b0;
    ID_to_PC_bus = '0;
    chk("valid_clr", {63'b0, vld0}, 64'd0);
    chk("req_after_handoff", {63'b0, req0}, 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    repeat (2) tick();
    chk("rst_req", {63'b0, req0}, 64'd0);
    chk("rst_addr", {32'b0, addr0}, 64'h0000_0000_BFC0_0000);
    chk("rst_valid", {63'b0, vld0}, 64'd0);
    chk("rst_bus", bus0, 64'd0);
    chk("rst_addr_u1", {32'b0, addr1}, 64'h0000_0000_FFFF_FFFC);
    reset = 1'b1;
    chk("idle_req", {63'b0, req0}, 64'd0);
    tick();
    chk("first_req", {63'b0, req0}, 64'd1);

    fetch(32'hBFC00000, 32'h24010001, '0, 0);
    chk("u1_bus_wrap", bus1, {32'h0000_0000, 32'h24010001});
    held = bus0;
    for (int i = 0; i < 5; i++) begin
      inst_data_ok = (i == 2);
      inst_rdata   = 32'hDEADBEEF;
      tick();
      inst_data_ok = 1'b0;
      chk("stall_bus", bus0, held);
      chk("stall_valid", {63'b0, vld0}, 64'd1);
      chk("stall_req", {63'b0, req0}, 64'd0);
    end
    handoff('0);
    chk("u1_second_addr", {32'b0, addr1}, 64'd0);

    fetch(32'hBFC00004, 32'h1000003E, '0, 0);
    handoff('0);
    fetch(32'hBFC00008, 32'h00000000, {32'hBFC00100, 32'h0, 32'h0, 2'b01}, 1);
    handoff('0);
    fetch(32'hBFC00100, 32'h03E00008, '0, 0);
    handoff('0);
    fetch(32'hBFC00104, 32'h00000000, {32'h0, 32'h0, 32'h80001003, 2'b11}, 1);
    handoff('0);
    fetch(32'h80001000, 32'h11111111, '0, 0);
    handoff({32'h0, 32'h00400010, 32'h0, 2'b10});
    fetch(32'h00400010, 32'h22222222, '0, 0);
    handoff('0);

    chk("pre_rst_addr", {32'b0, addr0}, 64'h0000_0000_0040_0014);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_req", {63'b0, req0}, 64'd0);
    chk("async_addr", {32'b0, addr0}, 64'h0000_0000_BFC0_0000);
    chk("async_valid", {63'b0, vld0}, 64'd0);
    chk("async_bus", bus0, 64'd0);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hCAFEF00D;
    tick();
    inst_data_ok = 1'b0;
    tick();
    chk("rst_dataok_valid", {63'b0, vld0}, 64'd0);
    chk("rst_dataok_bus", bus0, 64'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_req", {63'b0, req0}, 64'd1);
    fetch(32'hBFC00000, 32'h24010001, '0, 0);
    handoff('0);
    chk("post_rst_next", {32'b0, addr0}, 64'h0000_0000_BFC0_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
